int_rs_age: RTL and testbench
=============================

// Module: int_rs_age
// PURPOSE
// - Parametrised integer reservation station: generalises the single-CDB, in-order-slot int_rs.
// - Sits between rename/dispatch (ID) and one integer FU; PRF read happens after issue.
// - Holds DEPTH uops and wakes sources from CDB_WIDTH broadcast channels.
// - Issues the OLDEST ready entry through a valid/ready handshake; supports pipeline flush.
// PARAMETERS
// - DEPTH       8   number of RS entries (>=2)
// - CDB_WIDTH   2   number of CDB wakeup channels (>=1)
// - PRF_IDX_W   6   physical register index width
// - UOP_W       96  opaque payload width (pc, fu_opcode, op sels, imm, rob_id, rd_phy, rd_arch)
// PORTS
// - clk              in   1                     clock, all state on posedge
// - rst              in   1                     synchronous active-high reset
// - flush            in   1                     sync squash of all entries
// - from_id_valid    in   1                     dispatch request
// - from_id_ready    out  1                     RS can accept this cycle
// - from_id_uop      in   UOP_W                 payload
// - from_id_rs1_phy  in   PRF_IDX_W             src1 tag
// - from_id_rs1_valid in  1                     src1 used
// - from_id_rs1_rdy  in   1                     src1 value already in PRF
// - from_id_rs2_phy  in   PRF_IDX_W             src2 tag
// - from_id_rs2_valid in  1                     src2 used
// - from_id_rs2_rdy  in   1                     src2 value already in PRF
// - cdb_valid        in   CDB_WIDTH             per-channel broadcast valid
// - cdb_rd_phy       in   CDB_WIDTH*PRF_IDX_W   per-channel tag, channel k at [k*PRF_IDX_W +: PRF_IDX_W]
// - issue_valid      out  1                     an entry is selected
// - issue_ready      in   1                     FU accepts
// - issue_uop        out  UOP_W                 selected payload
// - issue_rs1_phy    out  PRF_IDX_W             selected src1 tag (to PRF read port)
// - issue_rs2_phy    out  PRF_IDX_W             selected src2 tag
// - occupancy        out  $clog2(DEPTH+1)       valid entry count
// BEHAVIOUR
// - Reset (rst=1): all entry valid bits 0; age matrix 0.
//   occupancy=0, from_id_ready=1, issue_valid=0.
//   Payload/tag fields are don't-care.
// - Per entry: valid, uop, rs{1,2}_phy, rs{1,2}_used, rs{1,2}_rdy.
//   An unused source, or a source with tag 0, is stored as rdy=1.
// - from_id_ready = (occupancy < DEPTH), registered state only.
//   No same-cycle bypass from issue to dispatch when full.
// - Dispatch on from_id_valid && from_id_ready: write the lowest-index free entry.
//   That entry becomes older than every currently valid entry.
// - Same-cycle wakeup: a CDB tag matching a dispatching source sets its rdy bit in the written entry.
// - Wakeup: each cycle, every valid entry with a source tag matching any cdb_valid[k] channel sets that rdy bit.
//   Multiple channels matching the same tag is harmless.
// - Select (combinational from registered state): candidate = valid && rs1_rdy && rs2_rdy.
//   - issue_valid = any candidate.
//   - Pick the candidate older than all other candidates, using the DEPTH x DEPTH age matrix.
// - Latency: a dispatch in cycle N can issue at the earliest in N+1.
//   A CDB wakeup in cycle N makes the entry eligible in N+1.
// - Issue handshake: the entry frees on issue_valid && issue_ready.
//   issue_* outputs hold steady while issue_valid && !issue_ready, unless an older entry becomes ready.
//   The older entry wins; re-selection is allowed and is not a protocol violation for this FU.
// - Simultaneous dispatch and issue: occupancy is unchanged.
//   The freed slot is reusable from the next cycle.
// - flush: all valid bits clear next cycle; dispatch in the same cycle is dropped.
//   issue_valid may be 1 in the flush cycle, but the FU must discard it (flush has priority).
// - rst has priority over flush, and over everything else.
// - Age matrix: on dispatch into slot i, row i is set to 0 for all valid j (i not older than any of them).
//   Column i is set to 1 for all valid j (every valid j is older than i).
//   On free, row i and column i are don't-care.
// - occupancy updates: +1 on dispatch, -1 on issue; never exceeds DEPTH or wraps.
// TESTING
// - Reset, then one dispatch (rs1_rdy=1, rs2 unused) in cycle N.
//   -> issue_valid=1 in N+1 with the same uop; occupancy 1 -> 0 after issue_ready.
// - Dispatch A(rs1=5, not rdy), then B(ready), then C(ready), issue_ready=1.
//   -> issue order B, C; A issues 1 cycle after cdb_valid[1]=1 with cdb_rd_phy ch1=5.
// - Fill all 8 entries with issue_ready=0.
//   -> from_id_ready=0, occupancy=8; one issue -> from_id_ready=1 next cycle.
// - Dispatch rs1=7 not rdy while cdb ch0 broadcasts 7 in the same cycle.
//   -> the entry issues in the following cycle.
// - Hold issue_ready=0 with 3 ready entries.
//   -> issue_* is stable and selects the oldest.
// - Pulse flush with 4 entries valid plus a concurrent dispatch.
//   -> occupancy=0, issue_valid=0 next cycle.
// - Reset mid-fill (5 entries valid).
//   -> all outputs return to their reset values one cycle after the rst edge.

Source files
------------

// File: rtl/int_rs_age.sv
// Integer reservation station with age-ordered select.
// Holds DEPTH uops, wakes sources from CDB_WIDTH broadcast channels and issues
// the oldest ready entry to a single integer FU through a valid/ready handshake.
module int_rs_age #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CDB_WIDTH = 2,
    parameter int unsigned PRF_IDX_W = 6,
    parameter int unsigned UOP_W     = 96
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           from_id_valid,
    output logic                           from_id_ready,
    input  logic [UOP_W-1:0]               from_id_uop,
    input  logic [PRF_IDX_W-1:0]           from_id_rs1_phy,
    input  logic                           from_id_rs1_valid,
    input  logic                           from_id_rs1_rdy,
    input  logic [PRF_IDX_W-1:0]           from_id_rs2_phy,
    input  logic                           from_id_rs2_valid,
    input  logic                           from_id_rs2_rdy,
    input  logic [CDB_WIDTH-1:0]           cdb_valid,
    input  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [UOP_W-1:0]               issue_uop,
    output logic [PRF_IDX_W-1:0]           issue_rs1_phy,
    output logic [PRF_IDX_W-1:0]           issue_rs2_phy,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry state
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     rs1_rdy_q;
    logic [DEPTH-1:0]     rs2_rdy_q;
    logic [UOP_W-1:0]     uop_q     [DEPTH];
    logic [PRF_IDX_W-1:0] rs1_phy_q [DEPTH];
    logic [PRF_IDX_W-1:0] rs2_phy_q [DEPTH];
    // age_q[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0]     age_q     [DEPTH];
    logic [OCC_W-1:0]     occ_q;

    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;
    logic             new1_rdy;
    logic             new2_rdy;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_found;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             dispatch;
    logic             issue_fire;

    assign from_id_ready = (occ_q < OCC_W'(DEPTH));
    assign occupancy     = occ_q;

    // CDB tag match for stored entries and for the uop being dispatched
    always_comb begin
        wake1    = '0;
        wake2    = '0;
        new1_rdy = !from_id_rs1_valid || (from_id_rs1_phy == '0) || from_id_rs1_rdy;
        new2_rdy = !from_id_rs2_valid || (from_id_rs2_phy == '0) || from_id_rs2_rdy;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rs1_phy_q[i] == cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]) wake1[i] = 1'b1;
                    if (rs2_phy_q[i] == cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]) wake2[i] = 1'b1;
                end
                if (from_id_rs1_phy == cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]) new1_rdy = 1'b1;
                if (from_id_rs2_phy == cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]) new2_rdy = 1'b1;
            end
        end
    end

    // Lowest-index free slot for dispatch
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest-ready select: a candidate wins if no other candidate is older
    always_comb begin
        cand    = valid_q & rs1_rdy_q & rs2_rdy_q;
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && age_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) sel_idx = sel_idx | IDX_W'(i);
        end
    end

    assign issue_valid   = |cand;
    assign issue_uop     = uop_q[sel_idx];
    assign issue_rs1_phy = rs1_phy_q[sel_idx];
    assign issue_rs2_phy = rs2_phy_q[sel_idx];

    assign dispatch   = from_id_valid && from_id_ready && alloc_found;
    assign issue_fire = issue_valid && issue_ready;

    // Valid bits, age matrix and occupancy; rst beats flush beats normal operation
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            if (issue_fire) valid_q[sel_idx] <= 1'b0;
            if (dispatch) begin
                valid_q[alloc_idx] <= 1'b1;
                // New entry is younger than everything currently held
                for (int j = 0; j < DEPTH; j++) begin
                    if (valid_q[j]) begin
                        age_q[alloc_idx][j] <= 1'b0;
                        age_q[j][alloc_idx] <= 1'b1;
                    end
                end
            end
            unique case ({dispatch, issue_fire})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Payload capture and source wakeup; contents are don't-care while invalid
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wake1[i]) rs1_rdy_q[i] <= 1'b1;
            if (wake2[i]) rs2_rdy_q[i] <= 1'b1;
        end
        if (dispatch) begin
            uop_q[alloc_idx]     <= from_id_uop;
            rs1_phy_q[alloc_idx] <= from_id_rs1_phy;
            rs2_phy_q[alloc_idx] <= from_id_rs2_phy;
            rs1_rdy_q[alloc_idx] <= new1_rdy;
            rs2_rdy_q[alloc_idx] <= new2_rdy;
        end
    end

endmodule

// File: tb/tb_int_rs_age.sv
// Self-checking bench for int_rs_age: directed scenarios plus randomized traffic
// against an age-ordered queue model of the reservation station.
module tb_int_rs_age;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        from_id_valid;
    logic        from_id_ready;
    logic [95:0] from_id_uop;
    logic [5:0]  from_id_rs1_phy;
    logic        from_id_rs1_valid;
    logic        from_id_rs1_rdy;
    logic [5:0]  from_id_rs2_phy;
    logic        from_id_rs2_valid;
    logic        from_id_rs2_rdy;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_rd_phy;
    logic        issue_valid;
    logic        issue_ready;
    logic [95:0] issue_uop;
    logic [5:0]  issue_rs1_phy;
    logic [5:0]  issue_rs2_phy;
    logic [3:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    int_rs_age #(
        .DEPTH    (8),
        .CDB_WIDTH(2),
        .PRF_IDX_W(6),
        .UOP_W    (96)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .from_id_valid    (from_id_valid),
        .from_id_ready    (from_id_ready),
        .from_id_uop      (from_id_uop),
        .from_id_rs1_phy  (from_id_rs1_phy),
        .from_id_rs1_valid(from_id_rs1_valid),
        .from_id_rs1_rdy  (from_id_rs1_rdy),
        .from_id_rs2_phy  (from_id_rs2_phy),
        .from_id_rs2_valid(from_id_rs2_valid),
        .from_id_rs2_rdy  (from_id_rs2_rdy),
        .cdb_valid        (cdb_valid),
        .cdb_rd_phy       (cdb_rd_phy),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_uop        (issue_uop),
        .issue_rs1_phy    (issue_rs1_phy),
        .issue_rs2_phy    (issue_rs2_phy),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: entries kept oldest-first
    typedef struct {
        logic [95:0] uop;
        logic [5:0]  p1;
        logic [5:0]  p2;
        bit          r1;
        bit          r2;
    } ent_t;

    ent_t        mq[$];
    logic [95:0] issued[$];

    function automatic bit hit(input logic [5:0] t);
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && (cdb_rd_phy[k*6 +: 6] == t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_pick();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) return i;
        end
        return -1;
    endfunction

    function automatic void m_update();
        int   p;
        bit   fire;
        bit   disp;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        p    = m_pick();
        fire = (p >= 0) && issue_ready;
        disp = from_id_valid && (mq.size() < 8);
        if (fire) mq.delete(p);
        for (int i = 0; i < mq.size(); i++) begin
            if (hit(mq[i].p1)) mq[i].r1 = 1'b1;
            if (hit(mq[i].p2)) mq[i].r2 = 1'b1;
        end
        if (disp) begin
            e.uop = from_id_uop;
            e.p1  = from_id_rs1_phy;
            e.p2  = from_id_rs2_phy;
            e.r1  = !from_id_rs1_valid || (from_id_rs1_phy == 6'd0) || from_id_rs1_rdy
                    || hit(from_id_rs1_phy);
            e.r2  = !from_id_rs2_valid || (from_id_rs2_phy == 6'd0) || from_id_rs2_rdy
                    || hit(from_id_rs2_phy);
            mq.push_back(e);
        end
    endfunction

    // Advance one clock; model follows the inputs presented at the edge
    task automatic tick();
        if (issue_valid && issue_ready && !flush && !rst) issued.push_back(issue_uop);
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush             = 1'b0;
        from_id_valid     = 1'b0;
        from_id_uop       = '0;
        from_id_rs1_phy   = '0;
        from_id_rs1_valid = 1'b0;
        from_id_rs1_rdy   = 1'b0;
        from_id_rs2_phy   = '0;
        from_id_rs2_valid = 1'b0;
        from_id_rs2_rdy   = 1'b0;
        cdb_valid         = '0;
        cdb_rd_phy        = '0;
    endtask

    task automatic set_disp(input logic [95:0] u, input logic [5:0] p1, input bit v1,
                            input bit r1, input logic [5:0] p2, input bit v2, input bit r2);
        from_id_valid     = 1'b1;
        from_id_uop       = u;
        from_id_rs1_phy   = p1;
        from_id_rs1_valid = v1;
        from_id_rs1_rdy   = r1;
        from_id_rs2_phy   = p2;
        from_id_rs2_valid = v2;
        from_id_rs2_rdy   = r2;
    endtask

    task automatic do_reset();
        idle();
        issue_ready = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        issued.delete();
    endtask

    task automatic test_reset();
        idle();
        issue_ready = 1'b0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (occupancy !== 4'd0) begin
            failures++;
            $display("FAIL reset_occ got=%0d want=0", occupancy);
        end
        checks++;
        if (from_id_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", from_id_ready);
        end
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_issue_valid got=%b want=0", issue_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_disp(96'hA1, 6'd3, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_no_bypass got=%b want=0", issue_valid);
        end
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b1 || issue_uop !== 96'hA1) begin
            failures++;
            $display("FAIL single_issue valid=%b uop=%h want valid=1 uop=a1", issue_valid,
                     issue_uop);
        end
        checks++;
        if (occupancy !== 4'd1) begin
            failures++;
            $display("FAIL single_occ1 got=%0d want=1", occupancy);
        end
        issue_ready = 1'b1;
        tick();
        checks++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain occ=%0d valid=%b want occ=0 valid=0", occupancy,
                     issue_valid);
        end
    endtask

    task automatic test_order();
        int n;
        do_reset();
        issue_ready = 1'b1;
        set_disp(96'hA, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        set_disp(96'hB, 6'd1, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1);
        tick();
        set_disp(96'hC, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        idle();
        n = 0;
        while (occupancy != 4'd1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (issue_valid !== 1'b0 || occupancy !== 4'd1) begin
            failures++;
            $display("FAIL order_a_waits valid=%b occ=%0d want valid=0 occ=1", issue_valid,
                     occupancy);
        end
        cdb_valid  = 2'b10;
        cdb_rd_phy = {6'd5, 6'd0};
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b1 || issue_uop !== 96'hA) begin
            failures++;
            $display("FAIL order_a_wake valid=%b uop=%h want valid=1 uop=a", issue_valid,
                     issue_uop);
        end
        tick();
        checks++;
        if (issued.size() != 3 || issued[0] !== 96'hB || issued[1] !== 96'hC
            || issued[2] !== 96'hA) begin
            failures++;
            $display("FAIL order_seq count=%0d want B,C,A", issued.size());
        end
    endtask

    task automatic test_fill();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_disp(96'(i + 16), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (from_id_ready !== 1'b0 || occupancy !== 4'd8) begin
            failures++;
            $display("FAIL fill_full ready=%b occ=%0d want ready=0 occ=8", from_id_ready,
                     occupancy);
        end
        set_disp(96'hDEAD, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (occupancy !== 4'd8) begin
            failures++;
            $display("FAIL fill_overflow occ=%0d want=8", occupancy);
        end
        idle();
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        checks++;
        if (from_id_ready !== 1'b1 || occupancy !== 4'd7) begin
            failures++;
            $display("FAIL fill_one_issue ready=%b occ=%0d want ready=1 occ=7", from_id_ready,
                     occupancy);
        end
        issue_ready = 1'b1;
        n = 0;
        while (occupancy != 4'd0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (occupancy !== 4'd0) begin
            failures++;
            $display("FAIL fill_drain_timeout occ=%0d want=0", occupancy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= issued.size() || issued[i] !== 96'(i + 16)) begin
                failures++;
                $display("FAIL fill_order idx=%0d want uop=%0d", i, i + 16);
            end
        end
    endtask

    task automatic test_same_cycle_wakeup();
        do_reset();
        set_disp(96'h77, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cdb_valid  = 2'b01;
        cdb_rd_phy = {6'd0, 6'd7};
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b1 || issue_uop !== 96'h77 || issue_rs1_phy !== 6'd7) begin
            failures++;
            $display("FAIL samecyc_wake valid=%b uop=%h rs1=%0d want 1/77/7", issue_valid,
                     issue_uop, issue_rs1_phy);
        end
        issue_ready = 1'b1;
        set_disp(96'h99, 6'd9, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b0 || occupancy !== 4'd1) begin
            failures++;
            $display("FAIL unwoken_blocked valid=%b occ=%0d want valid=0 occ=1", issue_valid,
                     occupancy);
        end
        cdb_valid  = 2'b11;
        cdb_rd_phy = {6'd9, 6'd9};
        tick();
        idle();
        tick();
        checks++;
        if (occupancy !== 4'd0) begin
            failures++;
            $display("FAIL dual_chan_wake occ=%0d want=0", occupancy);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_disp(96'hD0, 6'd20, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        set_disp(96'hD1, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1);
        tick();
        set_disp(96'hD2, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (issue_valid !== 1'b1 || issue_uop !== 96'hD1 || issue_rs2_phy !== 6'd3) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d valid=%b uop=%h want 1/d1", c, issue_valid,
                         issue_uop);
            end
            tick();
        end
        cdb_valid  = 2'b01;
        cdb_rd_phy = {6'd0, 6'd20};
        tick();
        idle();
        checks++;
        if (issue_uop !== 96'hD0 || issue_rs1_phy !== 6'd20) begin
            failures++;
            $display("FAIL hold_older_wins uop=%h want=d0", issue_uop);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_disp(96'(i + 48), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
            tick();
        end
        set_disp(96'hF5, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        idle();
        checks++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0 || from_id_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear occ=%0d valid=%b ready=%b want 0/0/1", occupancy,
                     issue_valid, from_id_ready);
        end
        tick();
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drops_dispatch valid=%b want=0", issue_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(96'(i + 64), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
            tick();
        end
        set_disp(96'hE0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        flush = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0 || from_id_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid occ=%0d valid=%b ready=%b want 0/0/1", occupancy,
                     issue_valid, from_id_ready);
        end
    endtask

    task automatic test_random();
        int p;
        int bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 299) == 0);
            flush             = ($urandom_range(0, 59) == 0);
            from_id_valid     = ($urandom_range(0, 3) != 0);
            from_id_uop       = {$urandom, $urandom, $urandom};
            from_id_rs1_phy   = 6'($urandom_range(0, 15));
            from_id_rs1_valid = $urandom_range(0, 1);
            from_id_rs1_rdy   = ($urandom_range(0, 3) == 0);
            from_id_rs2_phy   = 6'($urandom_range(0, 15));
            from_id_rs2_valid = $urandom_range(0, 1);
            from_id_rs2_rdy   = ($urandom_range(0, 3) == 0);
            cdb_valid         = 2'($urandom_range(0, 3));
            cdb_rd_phy        = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            issue_ready       = ($urandom_range(0, 9) < 6);
            p = m_pick();
            checks++;
            if (occupancy !== 4'(mq.size()) || from_id_ready !== (mq.size() < 8)
                || issue_valid !== (p >= 0)) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_ctrl cyc=%0d occ=%0d ready=%b valid=%b want %0d/%b/%b",
                             c, occupancy, from_id_ready, issue_valid, mq.size(),
                             mq.size() < 8, p >= 0);
            end else if (p >= 0) begin
                checks++;
                if (issue_uop !== mq[p].uop || issue_rs1_phy !== mq[p].p1
                    || issue_rs2_phy !== mq[p].p2) begin
                    failures++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL rand_sel cyc=%0d uop=%h rs1=%0d rs2=%0d want %h/%0d/%0d",
                                 c, issue_uop, issue_rs1_phy, issue_rs2_phy, mq[p].uop,
                                 mq[p].p1, mq[p].p2);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst         = 1'b1;
        issue_ready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_order();
        test_fill();
        test_same_cycle_wakeup();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
